snake_body_ctrl: RTL and testbench

//  Owns the snake: direction, head motion, body shift register, length and collision/death detection.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_next_head.sv | 86 ++++++++
 rtl/snake_body_ctrl.sv | 171 +++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game datapath: grid geometry defaults,
// body capacity, direction encodings and the body-controller state enum.
// Also used by the food generator and the renderer.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W   = 100;                  // grid columns
    localparam int GRID_H   = 75;                   // grid rows
    localparam int MAX_LEN  = 64;                   // body segment capacity
    localparam int POS_BITS = 13;                   // idx = y*GRID_W + x
    localparam int INIT_LEN = 3;                    // length after reset/restart
    localparam int LEN_BITS = $clog2(MAX_LEN) + 1;  // width of snake_length

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CALC,
        ST_SCAN,
        ST_COMMIT,
        ST_DEAD
    } state_e;

    // Opposite directions differ only in the upper encoding bit.
    function automatic dir_e dir_reverse(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// -----------------------------------------------------------------------------
// snake_next_head
// Combinational next-head calculator: current head x,y plus direction give
// the next x,y, its linear cell index (y*GRID_W + x, constant multiply, no
// divider) and a wall-hit flag.
// Configuration: WRAP_WALLS_EN defined -> edges wrap to the opposite side and
// o_wall_hit is never raised. Undefined -> o_wall_hit flags an edge exit.
// Ports:
//   i_x, i_y    current head column / row
//   i_dir       direction (snake_pkg::dir_e encoding)
//   o_x, o_y    next head column / row (already wrapped)
//   o_idx       next head linear index
//   o_wall_hit  next head would leave the grid
// -----------------------------------------------------------------------------
module snake_next_head #(
    parameter int GRID_W   = 100,
    parameter int GRID_H   = 75,
    parameter int POS_BITS = 13
) (
    input  logic [$clog2(GRID_W)-1:0] i_x,
    input  logic [$clog2(GRID_H)-1:0] i_y,
    input  logic [1:0]                i_dir,
    output logic [$clog2(GRID_W)-1:0] o_x,
    output logic [$clog2(GRID_H)-1:0] o_y,
    output logic [POS_BITS-1:0]       o_idx,
    output logic                      o_wall_hit
);
    import snake_pkg::*;

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

`ifdef WRAP_WALLS_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic w_wall;

    // The wrapped coordinate is always produced; without wrapping it is
    // simply never committed because the wall flag sends the FSM to DEAD.
    always_comb begin
        o_x    = i_x;
        o_y    = i_y;
        w_wall = 1'b0;
        case (i_dir)
            DIR_UP: begin
                if (i_y == '0) begin
                    w_wall = 1'b1;
                    o_y    = YW'(GRID_H - 1);
                end else begin
                    o_y = i_y - YW'(1);
                end
            end
            DIR_RIGHT: begin
                if (i_x == XW'(GRID_W - 1)) begin
                    w_wall = 1'b1;
                    o_x    = '0;
                end else begin
                    o_x = i_x + XW'(1);
                end
            end
            DIR_DOWN: begin
                if (i_y == YW'(GRID_H - 1)) begin
                    w_wall = 1'b1;
                    o_y    = '0;
                end else begin
                    o_y = i_y + YW'(1);
                end
            end
            default: begin
                if (i_x == '0) begin
                    w_wall = 1'b1;
                    o_x    = XW'(GRID_W - 1);
                end else begin
                    o_x = i_x - XW'(1);
                end
            end
        endcase
        o_idx = POS_BITS'(o_y) * POS_BITS'(GRID_W) + POS_BITS'(o_x);
    end

    assign o_wall_hit = w_wall && !WRAP_EN;

endmodule

// File: rtl/snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl
// Owns the snake: direction latch, head motion, body shift register, length
// counter and wall/self collision detection. A move is CALC (next head),
// SCAN (one body segment per cycle) and COMMIT (shift body in).
// Configuration: WRAP_WALLS_EN (see snake_next_head) selects wrapping edges
// instead of wall death.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   move_tick         1-cycle pulse, advance one cell (only honoured in RUN)
//   dir_req           requested direction, sampled on an accepted tick
//   start             1-cycle pulse: IDLE->RUN, DEAD->restart
//   food_pos          current food cell index
//   snake_body_flat   segment i at [i*POS_BITS +: POS_BITS], 0 = head
//   snake_length      number of valid segments
//   food_eaten        1-cycle pulse after a growing commit
//   game_over         high while DEAD
//   busy              high during CALC/SCAN/COMMIT
// -----------------------------------------------------------------------------
module snake_body_ctrl #(
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int POS_BITS = snake_pkg::POS_BITS,
    parameter int INIT_LEN = snake_pkg::INIT_LEN
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        move_tick,
    input  logic [1:0]                  dir_req,
    input  logic                        start,
    input  logic [POS_BITS-1:0]         food_pos,
    output logic [POS_BITS*MAX_LEN-1:0] snake_body_flat,
    output logic [$clog2(MAX_LEN):0]    snake_length,
    output logic                        food_eaten,
    output logic                        game_over,
    output logic                        busy
);
    import snake_pkg::*;

    localparam int XW       = $clog2(GRID_W);
    localparam int YW       = $clog2(GRID_H);
    localparam int LEN_W    = $clog2(MAX_LEN) + 1;
    localparam int SCAN_W   = $clog2(MAX_LEN);
    localparam int HEAD_X   = GRID_W / 2;
    localparam int HEAD_Y   = GRID_H / 2;
    localparam int HEAD_IDX = HEAD_Y * GRID_W + HEAD_X;

    state_e              r_state, w_state_nxt;
    dir_e                r_dir;
    logic [XW-1:0]       r_x, r_next_x, w_nx;
    logic [YW-1:0]       r_y, r_next_y, w_ny;
    logic [POS_BITS-1:0] r_next_idx, w_nidx;
    logic                r_grow;
    logic                w_wall;
    logic [POS_BITS-1:0] r_seg [MAX_LEN];
    logic [LEN_W-1:0]    r_len;
    logic [SCAN_W-1:0]   r_scan;
    logic                r_food_eaten;
    logic                w_scan_last;
    logic                w_scan_hit;

    snake_next_head #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .POS_BITS (POS_BITS)
    ) u_next_head (
        .i_x        (r_x),
        .i_y        (r_y),
        .i_dir      (r_dir),
        .o_x        (w_nx),
        .o_y        (w_ny),
        .o_idx      (w_nidx),
        .o_wall_hit (w_wall)
    );

    // The tail vacates on a non-growing move, so it cannot be hit then.
    assign w_scan_last = (LEN_W'(r_scan) == r_len - LEN_W'(1));
    assign w_scan_hit  = (r_seg[r_scan] == r_next_idx) && (r_grow || !w_scan_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start)     w_state_nxt = ST_RUN;
            ST_RUN:    if (move_tick) w_state_nxt = ST_CALC;
            ST_CALC:   w_state_nxt = w_wall ? ST_DEAD : ST_SCAN;
            ST_SCAN: begin
                if (w_scan_hit)       w_state_nxt = ST_DEAD;
                else if (w_scan_last) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: w_state_nxt = ST_RUN;
            ST_DEAD:   if (start)     w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == ST_CALC) || (r_state == ST_SCAN) || (r_state == ST_COMMIT);
        game_over = (r_state == ST_DEAD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dir        <= DIR_RIGHT;
            r_x          <= XW'(HEAD_X);
            r_y          <= YW'(HEAD_Y);
            r_len        <= LEN_W'(INIT_LEN);
            r_next_x     <= '0;
            r_next_y     <= '0;
            r_next_idx   <= '0;
            r_grow       <= 1'b0;
            r_scan       <= '0;
            r_food_eaten <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++)
                r_seg[i] <= (i < INIT_LEN) ? POS_BITS'(HEAD_IDX - i) : '0;
        end else begin
            r_food_eaten <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (move_tick && (dir_e'(dir_req) != dir_reverse(r_dir)))
                        r_dir <= dir_e'(dir_req);
                end
                ST_CALC: begin
                    r_next_x   <= w_nx;
                    r_next_y   <= w_ny;
                    r_next_idx <= w_nidx;
                    r_grow     <= (w_nidx == food_pos);
                    r_scan     <= '0;
                end
                ST_SCAN: r_scan <= r_scan + SCAN_W'(1);
                ST_COMMIT: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++)
                        r_seg[i] <= r_seg[i-1];
                    r_seg[0]     <= r_next_idx;
                    r_x          <= r_next_x;
                    r_y          <= r_next_y;
                    // At capacity the length saturates and the tail drops off.
                    if (r_grow && (r_len < LEN_W'(MAX_LEN)))
                        r_len <= r_len + LEN_W'(1);
                    r_food_eaten <= r_grow;
                end
                ST_DEAD: begin
                    if (start) begin
                        r_dir <= DIR_RIGHT;
                        r_x   <= XW'(HEAD_X);
                        r_y   <= YW'(HEAD_Y);
                        r_len <= LEN_W'(INIT_LEN);
                        for (int unsigned i = 0; i < MAX_LEN; i++)
                            r_seg[i] <= (i < INIT_LEN) ? POS_BITS'(HEAD_IDX - i) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        snake_body_flat = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            snake_body_flat[i*POS_BITS +: POS_BITS] = r_seg[i];
    end

    assign snake_length = r_len;
    assign food_eaten   = r_food_eaten;

endmodule

// File: tb/tb_snake_body_ctrl.sv
module tb_snake_body_ctrl;
    import snake_pkg::*;

    localparam int PB = POS_BITS;
    localparam int ML = MAX_LEN;
    localparam int LB = $clog2(MAX_LEN) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          move_tick = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    dir_req = 2'd0;
    logic [PB-1:0] food_pos = '0;
    logic [PB*ML-1:0] snake_body_flat;
    logic [LB-1:0] snake_length;
    logic          food_eaten, game_over, busy;

    snake_body_ctrl dut (
        .clk             (clk),
        .rstn            (rstn),
        .move_tick       (move_tick),
        .dir_req         (dir_req),
        .start           (start),
        .food_pos        (food_pos),
        .snake_body_flat (snake_body_flat),
        .snake_length    (snake_length),
        .food_eaten      (food_eaten),
        .game_over       (game_over),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        bit               over;
        bit               eaten;
        int               len;
        logic [PB*ML-1:0] body;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    // Reference model: snake as a list of (x,y) cells, head first.
    int mx[$];
    int my[$];
    int mdir;
    bit mdead;

    function automatic void chk(string nm, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk_body(string nm, logic [PB*ML-1:0] act, logic [PB*ML-1:0] exp);
        int first = -1;
        vectors++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < ML; i++)
                if (first < 0 && act[i*PB +: PB] !== exp[i*PB +: PB]) first = i;
            $display("FAIL %s: seg %0d got %0d, expected %0d", nm, first,
                     act[first*PB +: PB], exp[first*PB +: PB]);
        end
    endfunction

    function automatic logic [PB*ML-1:0] model_flat();
        logic [PB*ML-1:0] f = '0;
        for (int i = 0; i < mx.size(); i++)
            f[i*PB +: PB] = PB'(my[i] * GRID_W + mx[i]);
        return f;
    endfunction

    function automatic logic [PB*ML-1:0] len_mask(int len);
        logic [PB*ML-1:0] m = '0;
        for (int i = 0; i < len * PB && i < PB * ML; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            mx.push_back(GRID_W / 2 - i);
            my.push_back(GRID_H / 2);
        end
        mdir  = 1;
        mdead = 1'b0;
    endtask

    // Monitor: a move completes when busy falls (to RUN or DEAD).
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_completion: got completion at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("game_over", game_over, e.over);
                    chk("food_eaten", food_eaten, e.eaten);
                    chk("snake_length", snake_length, e.len);
                    chk_body("body", snake_body_flat & len_mask(e.len), e.body);
                end
            end else if (food_eaten) begin
                vectors++;
                errors++;
                $display("FAIL stray_food_eaten: got 1 at cycle %0d, expected 0", cyc);
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout: got %0d pending after %0d cycles, expected 0", sb.size(), n);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_move(int req, bit want_food);
        int dx[4] = '{0, 1, 0, -1};
        int dy[4] = '{-1, 0, 1, 0};
        int d, nx, ny, nidx, food, hit, len, t;
        bit grow, wall;
        exp_t e;

        d  = (req == ((mdir + 2) % 4)) ? mdir : req;
        nx = mx[0] + dx[d];
        ny = my[0] + dy[d];
        wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`ifdef WRAP_WALLS_EN
        nx   = (nx + GRID_W) % GRID_W;
        ny   = (ny + GRID_H) % GRID_H;
        wall = 1'b0;
`endif
        nidx = ny * GRID_W + nx;
        if (want_food && !wall) begin
            food = nidx;
        end else begin
            food = $urandom_range(0, GRID_W * GRID_H - 1);
            if (food == nidx) food = (food + 1) % (GRID_W * GRID_H);
        end
        grow = (food == nidx) && !wall;
        len  = mx.size();
        hit  = -1;
        if (!wall)
            for (int i = 0; i < len; i++)
                if (hit < 0 && mx[i] == nx && my[i] == ny && !(i == len - 1 && !grow)) hit = i;

        food_pos  = PB'(food);
        dir_req   = 2'(req);
        move_tick = 1'b1;
        t = cyc;

        if (wall || hit >= 0) begin
            e.cyc   = wall ? t + 2 : t + 3 + hit;
            e.over  = 1'b1;
            e.eaten = 1'b0;
            mdead   = 1'b1;
        end else begin
            mdir = d;
            mx.push_front(nx);
            my.push_front(ny);
            if (!grow || len == ML) begin
                void'(mx.pop_back());
                void'(my.pop_back());
            end
            e.cyc   = t + len + 3;
            e.over  = 1'b0;
            e.eaten = grow;
        end
        e.len  = mx.size();
        e.body = model_flat();
        sb.push_back(e);

        @(posedge clk);
        #1 move_tick = 1'b0;
        wait_done();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_image(string tag);
        chk({tag, "_len"}, snake_length, INIT_LEN);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_food_eaten"}, food_eaten, 0);
        chk_body({tag, "_body"}, snake_body_flat, model_flat());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_reset_image("reset");

        // Tick in IDLE is dropped.
        move_tick = 1'b1;
        @(posedge clk);
        #1 move_tick = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_reset_image("idle_tick");

        pulse_start();
        do_move(1, 1'b0);                 // head 3750 -> 3751
        chk("first_head", snake_body_flat[PB-1:0], 3751);
        do_move(1, 1'b1);                 // grow to 4
        do_move(3, 1'b0);                 // reverse request ignored
        do_move(0, 1'b0);
        do_move(3, 1'b0);
        do_move(2, 1'b0);                 // chases own tail cell
        chk("tail_chase_alive", game_over, 0);
        do_move(2, 1'b1);                 // grow to 5
        do_move(1, 1'b0);
        do_move(0, 1'b0);
        do_move(3, 1'b0);                 // into own neck
        chk("neck_dead", game_over, 1);

        pulse_start();                    // restart from DEAD
        model_reset();
        for (int i = 0; i < GRID_W - 1 - GRID_W / 2; i++) do_move(1, 1'b0);
        do_move(1, 1'b0);                 // off the right edge
`ifdef WRAP_WALLS_EN
        chk("wrap_head", snake_body_flat[PB-1:0], (GRID_H / 2) * GRID_W);
`else
        chk("wall_dead", game_over, 1);
`endif

        reset_dut();
        pulse_start();
        do_move(2, 1'b1);
        for (int i = 0; i < GRID_W / 2; i++) do_move(3, 1'b1);
        for (int i = 0; i < 12; i++) do_move(2, 1'b1);
        chk("saturated_len", snake_length, ML);

        // Reset in the middle of a long SCAN.
        food_pos  = PB'($urandom_range(0, GRID_W * GRID_H - 1));
        dir_req   = 2'd2;
        move_tick = 1'b1;
        @(posedge clk);
        #1 move_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_scan", busy, 1);
        reset_dut();
        check_reset_image("mid_scan_reset");

        // Randomised play with restarts.
        pulse_start();
        for (int n = 0; n < 150; n++) begin
            do_move($urandom_range(0, 3), ($urandom_range(0, 2) == 0));
            if (mdead) begin
                pulse_start();
                model_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                pulse_start();            // ignored while running
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
